// File: rtl/fpcvt_pkg.sv
// Shared constants and parameter helpers for the linear-to-float converter.
package fpcvt_pkg;

  localparam logic RND_HALF_UP = 1'b0;
  localparam logic RND_TRUNC   = 1'b1;

  function automatic int fp_out_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_e_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter; all-zero input returns W.
module fpcvt_lzc #(
  parameter int W  = 11,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] lz
);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) lz = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage elastic converter: sign/magnitude, normalise, round/saturate.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_cnt
);

  localparam int MAG_W = IN_W - 1;
  localparam int E_MAX = fp_e_max(EXP_W);
  localparam int OUT_W = fp_out_w(EXP_W, MAN_W);
  localparam int LZ_W  = $clog2(MAG_W + 1);
  localparam int E_THR = MAG_W - MAN_W;

  if (E_THR > E_MAX || MAN_W < 2) begin : g_param_err
    $fatal(1, "fpcvt_pipe: need MAG_W-MAN_W <= E_MAX and MAN_W >= 2");
  end

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // S1: the most negative sample has no positive twin and clamps to full scale
  logic [IN_W-1:0]  abs_c;
  logic [MAG_W-1:0] mag_c;
  logic             sat1_c;

  always_comb begin
    abs_c  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
    sat1_c = abs_c[IN_W-1];
    mag_c  = sat1_c ? '1 : abs_c[MAG_W-1:0];
  end

  logic             s1, sat1, rnd1;
  logic [MAG_W-1:0] mag1;

  // S2: extra zero LSB keeps the round-bit index valid when F spans the whole magnitude
  logic [LZ_W-1:0]  lz;
  logic [MAG_W:0]   norm_c;
  logic [EXP_W-1:0] e_c;
  logic [MAN_W-1:0] f_c;
  logic             r_c;

  fpcvt_lzc #(.W(MAG_W)) u_lzc (.din(mag1), .lz(lz));

  always_comb begin
    norm_c = {mag1, 1'b0} << lz;
    if (int'(lz) >= E_THR) begin
      e_c = '0;
      f_c = mag1[MAN_W-1:0];
      r_c = 1'b0;
    end else begin
      e_c = EXP_W'(E_THR - int'(lz));
      f_c = norm_c[MAG_W -: MAN_W];
      r_c = norm_c[MAG_W-MAN_W];
    end
  end

  logic             s2, r2, sat2, rnd2;
  logic [EXP_W-1:0] e2;
  logic [MAN_W-1:0] f2;

  // S3: round, renormalise on carry, clamp on exponent overflow
  logic [MAN_W:0]   fr_c;
  logic [EXP_W:0]   er_c;
  logic [OUT_W-1:0] code_c;
  logic             sat3_c;

  always_comb begin
    fr_c   = {1'b0, f2} + (MAN_W+1)'(r2 && (rnd2 == RND_HALF_UP));
    er_c   = {1'b0, e2};
    sat3_c = sat2;
    if (fr_c[MAN_W]) begin
      fr_c = (MAN_W+1)'(1) << (MAN_W - 1);
      er_c = er_c + (EXP_W+1)'(1);
    end
    code_c = {s2, er_c[EXP_W-1:0], fr_c[MAN_W-1:0]};
    if (er_c > (EXP_W+1)'(E_MAX)) begin
      code_c = {s2, EXP_W'(E_MAX), {MAN_W{1'b1}}};
      sat3_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; s1 <= 1'b0; mag1 <= '0; sat1 <= 1'b0; rnd1 <= 1'b0;
      v2 <= 1'b0; s2 <= 1'b0; e2 <= '0; f2 <= '0; r2 <= 1'b0; sat2 <= 1'b0; rnd2 <= 1'b0;
      v3 <= 1'b0; out_data <= '0; out_sat <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1   <= in_data[IN_W-1];
          mag1 <= mag_c;
          sat1 <= sat1_c;
          rnd1 <= in_rnd;
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          s2   <= s1;
          e2   <= e_c;
          f2   <= f_c;
          r2   <= r_c;
          sat2 <= sat1;
          rnd2 <= rnd1;
        end
      end
      if (ld3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= code_c;
          out_sat  <= sat3_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (v3 && out_ready && out_sat && (sat_cnt != '1))
      sat_cnt <= sat_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed bench for fpcvt_pipe; second instance exercises a 2-bit saturation counter.
module tb_fpcvt_pipe;
  import fpcvt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_rnd = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, out_valid, out_sat;
  logic [7:0]  out_data;
  logic [15:0] sat_cnt;
  logic        in_ready2, out_valid2, out_sat2;
  logic [7:0]  out_data2;
  logic [1:0]  sat_cnt2;

  fpcvt_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rnd(in_rnd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_clr(sat_clr), .sat_cnt(sat_cnt));

  fpcvt_pipe #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_rnd(in_rnd), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_sat(out_sat2), .sat_clr(sat_clr), .sat_cnt(sat_cnt2));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    logic       sat;
    int         acc;
    bit         lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   lat_chk = 0, rand_rdy = 0;
  logic prev_stall = 1'b0, prev_sat;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, hold check under stall
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL extra_code: observed %02h expected no code", out_data);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("code", 32'(out_data), 32'(mon_e.code));
          check("sat", 32'(out_sat), 32'(mon_e.sat));
          check("code_cnt2", 32'(out_data2), 32'(mon_e.code));
          if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc), 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Independent reference: locate MSB by search, then round and clamp
  function automatic logic [8:0] ref_cvt(input logic [11:0] d, input logic r);
    int v, m, p, e, f;
    logic s, sat;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    sat = 1'b0;
    if (m > 2047) begin m = 2047; sat = 1'b1; end
    if (m < 16) begin
      e = 0; f = m;
    end else begin
      p = 10;
      while (((m >> p) & 1) == 0) p--;
      e = p - 3;
      f = m >> (p - 3);
      if (!r && (((m >> (p - 4)) & 1) == 1)) f++;
      if (f == 16) begin f = 8; e++; end
      if (e > 7) begin e = 7; f = 15; sat = 1'b1; end
    end
    return {sat, s, 3'(e), 4'(f)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [7:0] code, input logic sat);
    exp_t e;
    e.code = code; e.sat = sat; e.acc = cyc; e.lat = lat_chk;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [11:0] d, input logic r, input logic [7:0] code, input logic sat);
    int g = 0;
    bit acc = 0;
    in_valid = 1'b1; in_data = d; in_rnd = r;
    while (!acc && g < 100) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else begin g++; tick(); end
    end
    n_vec++;
    assert (acc) else begin
      n_err++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
    end
    if (acc) push(code, sat);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin tick(); g++; end
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
  endtask

  logic [11:0] bp_d[4] = '{12'd100, 12'hFF9, 12'd1000, 12'hFF0};
  logic [7:0]  bp_c[4] = '{8'h3D, 8'h87, 8'h78, 8'h98};

  initial begin
    int idx, g;
    logic [11:0] rd;
    logic        rr;
    logic [8:0]  rc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back with latency check
    lat_chk = 1;
    send(12'd0,           RND_HALF_UP, 8'h00, 1'b0);
    send(12'(-40),        RND_HALF_UP, 8'hAA, 1'b0);
    send(12'd56,          RND_HALF_UP, 8'h2E, 1'b0);
    send(12'd422,         RND_HALF_UP, 8'h5D, 1'b0);
    send(12'(-422),       RND_HALF_UP, 8'hDD, 1'b0);
    lat_chk = 0;
    drain();

    // Rounding carry vs truncate, interleaved; small-magnitude boundaries
    send(12'd63,  RND_HALF_UP, 8'h38, 1'b0);
    send(12'd63,  RND_TRUNC,   8'h2F, 1'b0);
    send(12'd63,  RND_HALF_UP, 8'h38, 1'b0);
    send(12'd63,  RND_TRUNC,   8'h2F, 1'b0);
    send(12'(-5), RND_HALF_UP, 8'h85, 1'b0);
    send(12'd15,  RND_HALF_UP, 8'h0F, 1'b0);
    send(12'(-16),RND_HALF_UP, 8'h98, 1'b0);
    send(12'd1000,RND_HALF_UP, 8'h78, 1'b0);
    drain();

    // Saturation and counter
    send(12'd2047,   RND_HALF_UP, 8'h7F, 1'b1);
    send(12'h800,    RND_TRUNC,   8'hFF, 1'b1);
    drain();
    check("sat_cnt_2", 32'(sat_cnt), 32'd2);
    check("sat_cnt2_2", 32'(sat_cnt2), 32'd2);

    out_ready = 1'b0;
    send(12'd2047, RND_HALF_UP, 8'h7F, 1'b1);
    g = 0;
    while (!out_valid && g < 10) begin tick(); g++; end
    check("sat3_out_valid", 32'(out_valid), 32'd1);
    sat_clr = 1'b1; out_ready = 1'b1;
    tick();
    sat_clr = 1'b0;
    drain();
    check("sat_clr_wins", 32'(sat_cnt), 32'd0);

    for (int i = 0; i < 5; i++) send(12'h800, RND_HALF_UP, 8'hFF, 1'b1);
    drain();
    check("sat_cnt_5", 32'(sat_cnt), 32'd5);
    check("sat_cnt2_hold", 32'(sat_cnt2), 32'd3);

    // Backpressure with in_valid held
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_data = bp_d[0]; in_rnd = RND_HALF_UP;
    repeat (10) begin
      @(negedge clk);
      if (in_ready && idx < 4) begin push(bp_c[idx], 1'b0); idx++; end
      tick();
      if (idx < 4) in_data = bp_d[idx];
    end
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_in_ready2", 32'(in_ready2), 32'd0);
    out_ready = 1'b1;
    g = 0;
    while (idx < 4 && g < 20) begin
      @(negedge clk);
      if (in_ready) begin push(bp_c[idx], 1'b0); idx++; end
      tick();
      g++;
    end
    in_valid = 1'b0;
    check("bp_all_in", 32'(idx), 32'd4);
    drain();

    // Random stream with random out_ready
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      rd = 12'($urandom);
      rr = 1'($urandom_range(0, 1));
      rc = ref_cvt(rd, rr);
      send(rd, rr, rc[7:0], rc[8]);
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();

    // Mid-stream reset with a full pipeline
    out_ready = 1'b0;
    send(12'd56, RND_HALF_UP, 8'h2E, 1'b0);
    send(12'd63, RND_HALF_UP, 8'h38, 1'b0);
    send(12'd2047, RND_HALF_UP, 8'h7F, 1'b1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("mrst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) tick();
    check("mrst_no_stale", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
